// File: rtl/hw_stack.sv
// hw_stack -- LIFO stack unit that owns its own stack pointer.
//
// The core only issues push/pop; this block tracks occupancy, presents the
// top-of-stack combinationally and flags rejected operations with sticky
// error bits. Used for both the call/return stack and the expression stack.
//
// Parameters:
//   WIDTH  data word width
//   DEPTH  number of entries (>= 2, any value)
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous, active-high reset
//   push       push data_in this cycle
//   pop        pop the top entry this cycle
//   data_in    value to push
//   clr_err    clears overflow/underflow (a same-cycle new error still sets)
//   tos        top of stack, 0 when empty
//   count      number of valid entries, 0..DEPTH
//   empty      count == 0
//   full       count == DEPTH
//   overflow   sticky: a push was rejected
//   underflow  sticky: a pop was rejected
//
// Optional build macro HW_STACK_PEEK_EN adds:
//   peek_idx    entry offset below the top to read
//   peek_data   mem[count-1-peek_idx], 0 when not valid
//   peek_valid  peek_idx < count
module hw_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       clr_err,
`ifdef HW_STACK_PEEK_EN
  input  logic [$clog2(DEPTH)-1:0]   peek_idx,
  output logic [WIDTH-1:0]           peek_data,
  output logic                       peek_valid,
`endif
  output logic [WIDTH-1:0]           tos,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_en;
  logic [PW-1:0]    wr_addr;
  logic [PW-1:0]    top_idx;

  logic             is_empty;
  logic             is_full;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));

  // Only meaningful when not empty; tos is masked otherwise.
  assign top_idx  = PW'(count_q - CW'(1));

  always_comb begin
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    wr_en       = 1'b0;
    wr_addr     = '0;

    // Clear first so that an error raised in the same cycle wins.
    if (clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end

    unique case ({push, pop})
      2'b10: begin
        if (is_full) begin
          overflow_d = 1'b1;
        end else begin
          wr_en   = 1'b1;
          wr_addr = PW'(count_q);
          count_d = count_q + CW'(1);
        end
      end
      2'b01: begin
        if (is_empty) begin
          underflow_d = 1'b1;
        end else begin
          count_d = count_q - CW'(1);
        end
      end
      2'b11: begin
        if (is_empty) begin
          // Pop has nothing to remove; the push still goes in at slot 0.
          underflow_d = 1'b1;
          wr_en       = 1'b1;
          wr_addr     = '0;
          count_d     = CW'(1);
        end else begin
          // Replace top: legal even when full since occupancy is unchanged.
          wr_en   = 1'b1;
          wr_addr = top_idx;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately not reset; only occupied slots are ever read out.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= data_in;
    end
  end

  assign tos       = is_empty ? '0 : mem_q[top_idx];
  assign count     = count_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

`ifdef HW_STACK_PEEK_EN
  logic [CW-1:0] peek_ext;
  logic [PW-1:0] peek_addr;

  assign peek_ext   = CW'(peek_idx);
  assign peek_valid = (peek_ext < count_q);
  assign peek_addr  = PW'(count_q - CW'(1) - peek_ext);
  assign peek_data  = peek_valid ? mem_q[peek_addr] : '0;
`endif

endmodule

// File: tb/tb_hw_stack.sv
// Directed bench for hw_stack at DEPTH=4, WIDTH=16. Inputs change 1 time
// unit after a rising edge and outputs are sampled there as well.
module tb_hw_stack;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH+1);

  logic             clk;
  logic             reset;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] data_in;
  logic             clr_err;
  logic [WIDTH-1:0] tos;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;
`ifdef HW_STACK_PEEK_EN
  logic [PW-1:0]    peek_idx;
  logic [WIDTH-1:0] peek_data;
  logic             peek_valid;
`endif

  int n_checks = 0;
  int n_errors = 0;

  hw_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .data_in   (data_in),
    .clr_err   (clr_err),
`ifdef HW_STACK_PEEK_EN
    .peek_idx  (peek_idx),
    .peek_data (peek_data),
    .peek_valid(peek_valid),
`endif
    .tos       (tos),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply one operation for one clock, then return inputs to idle.
  task automatic op(input logic p_push, input logic p_pop, input logic [WIDTH-1:0] d,
                    input logic p_clr);
    push    = p_push;
    pop     = p_pop;
    data_in = d;
    clr_err = p_clr;
    @(posedge clk);
    #1;
    push    = 1'b0;
    pop     = 1'b0;
    clr_err = 1'b0;
    data_in = '0;
  endtask

  task automatic check_state(input string tag, input int exp_count, input logic [WIDTH-1:0] exp_tos,
                             input logic exp_ovf, input logic exp_unf);
    check({tag, ".count"}, 32'(count), 32'(exp_count));
    check({tag, ".tos"}, 32'(tos), 32'(exp_tos));
    check({tag, ".empty"}, 32'(empty), 32'(exp_count == 0));
    check({tag, ".full"}, 32'(full), 32'(exp_count == DEPTH));
    check({tag, ".ovf"}, 32'(overflow), 32'(exp_ovf));
    check({tag, ".unf"}, 32'(underflow), 32'(exp_unf));
  endtask

  initial begin
    reset   = 1'b1;
    push    = 1'b0;
    pop     = 1'b0;
    data_in = '0;
    clr_err = 1'b0;
`ifdef HW_STACK_PEEK_EN
    peek_idx = '0;
`endif
    #2;
    check_state("reset", 0, 16'h0, 1'b0, 1'b0);
`ifdef HW_STACK_PEEK_EN
    check("reset.peek_valid", 32'(peek_valid), 32'd0);
    check("reset.peek_data", 32'(peek_data), 32'd0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Basic push/pop ordering.
    op(1'b1, 1'b0, 16'h1111, 1'b0);
    op(1'b1, 1'b0, 16'h2222, 1'b0);
    op(1'b1, 1'b0, 16'h3333, 1'b0);
    check_state("push3", 3, 16'h3333, 1'b0, 1'b0);
    op(1'b0, 1'b1, 16'h0, 1'b0);
    check_state("pop1", 2, 16'h2222, 1'b0, 1'b0);
    op(1'b0, 1'b1, 16'h0, 1'b0);
    check_state("pop2", 1, 16'h1111, 1'b0, 1'b0);
    op(1'b0, 1'b1, 16'h0, 1'b0);
    check_state("pop3", 0, 16'h0, 1'b0, 1'b0);

    // Fill and overflow.
    for (int i = 1; i <= 4; i++) op(1'b1, 1'b0, 16'(i), 1'b0);
    check_state("fill", 4, 16'h4, 1'b0, 1'b0);
    op(1'b1, 1'b0, 16'h5, 1'b0);
    check_state("ovf", 4, 16'h4, 1'b1, 1'b0);
    op(1'b0, 1'b0, 16'h0, 1'b1);
    check_state("ovf_clr", 4, 16'h4, 1'b0, 1'b0);

    // Replace at full: no overflow, count held.
    op(1'b1, 1'b1, 16'h7777, 1'b0);
    check_state("repl_full", 4, 16'h7777, 1'b0, 1'b0);
    op(1'b0, 1'b1, 16'h0, 1'b0);
    check_state("pop_after_repl", 3, 16'h3, 1'b0, 1'b0);
    op(1'b0, 1'b1, 16'h0, 1'b0);
    check_state("pop_to2", 2, 16'h2, 1'b0, 1'b0);
    op(1'b1, 1'b1, 16'hAAAA, 1'b0);
    check_state("repl_a", 2, 16'hAAAA, 1'b0, 1'b0);
    op(1'b1, 1'b1, 16'hBBBB, 1'b0);
    check_state("repl_b", 2, 16'hBBBB, 1'b0, 1'b0);
    op(1'b0, 1'b1, 16'h0, 1'b0);
    check_state("below_repl", 1, 16'h1, 1'b0, 1'b0);
    op(1'b0, 1'b1, 16'h0, 1'b0);
    check_state("drain", 0, 16'h0, 1'b0, 1'b0);

    // Underflow and set-wins-over-clear.
    op(1'b0, 1'b1, 16'h0, 1'b0);
    check_state("unf", 0, 16'h0, 1'b0, 1'b1);
    op(1'b0, 1'b1, 16'h0, 1'b1);
    check_state("unf_clr_same", 0, 16'h0, 1'b0, 1'b1);
    op(1'b0, 1'b0, 16'h0, 1'b1);
    check_state("unf_clr", 0, 16'h0, 1'b0, 1'b0);

    // Push+pop when empty: push lands, underflow raised.
    op(1'b1, 1'b1, 16'hCCCC, 1'b0);
    check_state("pp_empty", 1, 16'hCCCC, 1'b0, 1'b1);
    op(1'b0, 1'b1, 16'h0, 1'b0);
    check_state("pp_empty_pop", 0, 16'h0, 1'b0, 1'b1);

    // Asynchronous reset mid-burst, with a sticky flag set.
    op(1'b1, 1'b0, 16'hA001, 1'b0);
    op(1'b1, 1'b0, 16'hA002, 1'b0);
    op(1'b1, 1'b0, 16'hA003, 1'b0);
    check_state("burst", 3, 16'hA003, 1'b0, 1'b1);
    push    = 1'b1;
    data_in = 16'hA004;
    #2;
    reset = 1'b1;
    #1;
    check_state("async_rst", 0, 16'h0, 1'b0, 1'b0);
    #1;
    reset   = 1'b0;
    push    = 1'b0;
    data_in = '0;
    @(posedge clk);
    #1;
    check_state("post_rst_idle", 0, 16'h0, 1'b0, 1'b0);
    op(1'b1, 1'b0, 16'h5A5A, 1'b0);
    check_state("post_rst_push", 1, 16'h5A5A, 1'b0, 1'b0);
    op(1'b0, 1'b1, 16'h0, 1'b0);
    check_state("post_rst_pop", 0, 16'h0, 1'b0, 1'b0);

`ifdef HW_STACK_PEEK_EN
    op(1'b1, 1'b0, 16'd10, 1'b0);
    op(1'b1, 1'b0, 16'd20, 1'b0);
    op(1'b1, 1'b0, 16'd30, 1'b0);
    begin
      logic [WIDTH-1:0] exp_pk [3];
      exp_pk[0] = 16'd30;
      exp_pk[1] = 16'd20;
      exp_pk[2] = 16'd10;
      for (int i = 0; i < 3; i++) begin
        peek_idx = PW'(i);
        #1;
        check($sformatf("peek%0d.data", i), 32'(peek_data), 32'(exp_pk[i]));
        check($sformatf("peek%0d.valid", i), 32'(peek_valid), 32'd1);
      end
    end
    peek_idx = PW'(3);
    #1;
    check("peek3.data", 32'(peek_data), 32'd0);
    check("peek3.valid", 32'(peek_valid), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
